// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one RAM port between instruction fetch, the scalar load/store unit
// and the matrix load/store unit. One access is in flight at a time, and the
// access sequence is IDLE -> ACCESS -> DONE.
//
// Ports:
//   CLK, rst                      clock (rising edge), async active-high reset
//   imemREN/imemaddr              fetch read request (read only)
//   ihit/imemload                 fetch completion pulse and read data
//   dmemREN/dmemWEN/dmemaddr/dmemstore   scalar request
//   dhit/dmemload                 scalar completion pulse and read data
//   mlsREN/mlsWEN/mlsaddr/mlsstore       matrix LS request
//   mhit/mlsload                  matrix completion pulse and read data
//   ramREN/ramWEN/ramaddr/ramstore       shared RAM port, driven in ACCESS only
//   ramload/ram_ready             RAM read data and completion (variable latency)
//   owner                         grant: 0 none, 1 fetch, 2 scalar, 3 matrix
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          imemREN,
    input  logic [AW-1:0] imemaddr,
    output logic          ihit,
    output logic [DW-1:0] imemload,
    input  logic          dmemREN,
    input  logic          dmemWEN,
    input  logic [AW-1:0] dmemaddr,
    input  logic [DW-1:0] dmemstore,
    output logic          dhit,
    output logic [DW-1:0] dmemload,
    input  logic          mlsREN,
    input  logic          mlsWEN,
    input  logic [AW-1:0] mlsaddr,
    input  logic [DW-1:0] mlsstore,
    output logic          mhit,
    output logic [DW-1:0] mlsload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic          ram_ready,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic       rr_matrix;   // 0: scalar has round-robin priority, 1: matrix
    logic [3:0] starve;      // decisions fetch has lost in a row

    logic          fetch_req;
    logic          scalar_req;
    logic          matrix_req;
    logic [1:0]    win;
    logic          win_write;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_store;

    assign fetch_req  = imemREN;
    assign scalar_req = dmemREN | dmemWEN;
    assign matrix_req = mlsREN | mlsWEN;

    // Winner selection: a starved fetch first, then the data requester at the
    // round-robin pointer, then the other data requester, then fetch.
    always_comb begin
        win       = 2'd0;
        win_write = 1'b0;
        win_addr  = '0;
        win_store = '0;
        if (fetch_req && starve >= LIMIT) begin
            win = 2'd1;
        end else if (!rr_matrix && scalar_req) begin
            win = 2'd2;
        end else if (rr_matrix && matrix_req) begin
            win = 2'd3;
        end else if (scalar_req) begin
            win = 2'd2;
        end else if (matrix_req) begin
            win = 2'd3;
        end else if (fetch_req) begin
            win = 2'd1;
        end
        case (win)
            2'd1: begin
                win_addr = imemaddr;
            end
            2'd2: begin
                win_write = dmemWEN;   // REN+WEN together is a write
                win_addr  = dmemaddr;
                win_store = dmemstore;
            end
            2'd3: begin
                win_write = mlsWEN;
                win_addr  = mlsaddr;
                win_store = mlsstore;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_matrix <= 1'b0;
            starve    <= '0;
            owner     <= 2'd0;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= '0;
            ramstore  <= '0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            mhit      <= 1'b0;
            imemload  <= '0;
            dmemload  <= '0;
            mlsload   <= '0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            mhit <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fetch_req || win == 2'd1) begin
                        starve <= '0;
                    end else if (starve < LIMIT) begin
                        starve <= starve + 4'd1;
                    end
                    if (win != 2'd0) begin
                        owner    <= win;
                        ramREN   <= ~win_write;
                        ramWEN   <= win_write;
                        ramaddr  <= win_addr;
                        ramstore <= win_store;
                        state    <= ACCESS;
                        if (win == 2'd2) begin
                            rr_matrix <= 1'b1;
                        end else if (win == 2'd3) begin
                            rr_matrix <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (ram_ready) begin
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= '0;
                        ramstore <= '0;
                        state    <= DONE;
                        // The hit register is set here so it is high for the
                        // whole DONE cycle; writes return zero data.
                        case (owner)
                            2'd1: begin
                                ihit     <= 1'b1;
                                imemload <= ramWEN ? '0 : ramload;
                            end
                            2'd2: begin
                                dhit     <= 1'b1;
                                dmemload <= ramWEN ? '0 : ramload;
                            end
                            2'd3: begin
                                mhit    <= 1'b1;
                                mlsload <= ramWEN ? '0 : ramload;
                            end
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    owner <= 2'd0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
